// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_pkg
// Description : Shared defaults and one-hot helper for the round-robin mux.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

  localparam int MUX_N_DEF = 4;
  localparam int MUX_W_DEF = 8;
  localparam int MUX_N_MAX = 16;
  localparam int MUX_IDX_W = 4;

  // OR-reduction encoder: the result is valid only for a one-hot (or zero) input.
  function automatic logic [MUX_IDX_W-1:0] onehot2idx(input logic [MUX_N_MAX-1:0] oh);
    logic [MUX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MUX_N_MAX; i++) begin
      if (oh[i]) idx = idx | MUX_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_rr_n_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter with optional grant lock to the last winner.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N = MUX_N_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  input  logic         lock,
  output logic [N-1:0] gnt
);

  localparam int SW = $clog2(N);

  logic [SW-1:0] r_ptr;
  logic [N-1:0]  w_gnt;
  logic          w_found;
  logic [SW:0]   w_sum;
  logic [SW-1:0] w_idx;

  // Search starts one past the last winner and wraps modulo N.
  always_comb begin
    w_gnt   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    if (lock) begin
      if (req[r_ptr]) w_gnt[r_ptr] = 1'b1;
    end else begin
      for (int i = 1; i <= N; i++) begin
        w_sum = (SW+1)'(r_ptr) + (SW+1)'(i);
        if (w_sum >= (SW+1)'(N)) w_sum = w_sum - (SW+1)'(N);
        w_idx = w_sum[SW-1:0];
        if (!w_found && req[w_idx]) begin
          w_gnt[w_idx] = 1'b1;
          w_found      = 1'b1;
        end
      end
    end
  end

  assign gnt = w_gnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= SW'(N - 1);
    end else if (advance) begin
      r_ptr <= SW'(onehot2idx(MUX_N_MAX'(w_gnt)));
    end
  end

endmodule
`default_nettype wire

// File: rtl/mux_rr_n.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_n
// Description : N-channel valid/ready merge with round-robin arbitration and a
//               registered output. Define MUX_RR_LOCK_EN to add in_last packet lock.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_rr_n
  import mux_pkg::*;
#(
  parameter  int N  = MUX_N_DEF,
  parameter  int W  = MUX_W_DEF,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
`ifdef MUX_RR_LOCK_EN
  input  logic [N-1:0]   in_last,
`endif
  output logic [N-1:0]   in_ready,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_sel,
  output logic           out_valid,
  input  logic           out_ready
);

  logic [N-1:0]  w_gnt;
  logic          w_load;
  logic          w_xfer;
  logic          w_lock;
  logic [W-1:0]  w_data;
  logic [W-1:0]  r_data;
  logic [SW-1:0] r_sel;
  logic          r_valid;

  assign w_load   = ~r_valid | out_ready;
  // Gating with rst_n keeps producers from seeing a handshake that reset would discard.
  assign in_ready = w_gnt & {N{w_load & rst_n}};
  assign w_xfer   = |(in_ready & in_valid);

  rr_arbiter #(
    .N (N)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (in_valid),
    .advance (w_xfer),
    .lock    (w_lock),
    .gnt     (w_gnt)
  );

`ifdef MUX_RR_LOCK_EN
  logic r_locked;
  logic w_last_g;

  assign w_last_g = |(w_gnt & in_last);
  assign w_lock   = r_locked;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_locked <= 1'b0;
    end else if (w_xfer) begin
      r_locked <= ~w_last_g;
    end
  end
`else
  assign w_lock = 1'b0;
`endif

  always_comb begin
    w_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_gnt[i]) w_data = w_data | in_data[i*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
    end else if (w_load) begin
      if (w_xfer) begin
        r_valid <= 1'b1;
        r_data  <= w_data;
        r_sel   <= SW'(onehot2idx(MUX_N_MAX'(w_gnt)));
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_sel   = r_sel;

endmodule
`default_nettype wire
